incdec_ex: RTL and testbench
============================

INCDEC_EX -- requirements
Module: incdec_ex

Interface
REQ-001 SHALL have parameter WIDTH, default 16, address width; even, >= 4; HALF = WIDTH/2.
REQ-002 SHALL have parameter CNTW, default 8, step-count width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of CLK.
REQ-004 Ports:
- CLK  input  1  clock.
- RES  input  1  asynchronous active-high reset.
- LD  input  1  load AREG from DIN.
- DIN  input  WIDTH  load value.
- CMD_VALID  input  1  command request.
- CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY.
- CMD_DEC  input  1  0 = increment, 1 = decrement.
- CMD_PAIR  input  1  1 = full-width carry chain; 0 = low half only.
- CMD_CNT  input  CNTW  number of steps.
- BUS_DISABLE  input  1  1 = freeze A and pause stepping.
- A  output  WIDTH  registered external address.
- AREG_Q  output  WIDTH  internal address register.
- CARRY  output  1  sticky wrap flag.
- DONE  output  1  one-cycle completion pulse.

Function
REQ-005 SHALL implement FSM states IDLE, RUN and DONE.
REQ-006 CMD_READY SHALL equal (state==IDLE) & ~LD.
REQ-007 LD in IDLE SHALL load AREG<=DIN at the edge; LD SHALL win over CMD_VALID in the same cycle.
REQ-008 LD in RUN or DONE SHALL abort: AREG<=DIN, state<=IDLE, remaining count cleared, no DONE pulse.
REQ-009 On accept at edge T, the block SHALL latch CMD_DEC/CMD_PAIR, set REM<=CMD_CNT and clear CARRY.
REQ-010 On that accept edge: state<=RUN if CMD_CNT!=0; state<=DONE if CMD_CNT==0, with no step taken.
REQ-011 In RUN, each edge with BUS_DISABLE=0 SHALL apply one step to AREG and set REM<=REM-1.
REQ-012 In RUN, the step where REM==1 SHALL also set state<=DONE.
REQ-013 In RUN, an edge with BUS_DISABLE=1 SHALL leave AREG, REM and state unchanged.
REQ-014 For N>=1 with no pauses, steps SHALL land at edges T+1..T+N, DONE SHALL be high for the cycle after edge T+N, and state SHALL return to IDLE at edge T+N+1.
REQ-015 DONE SHALL equal (state==DONE); DONE SHALL last exactly one cycle, independent of BUS_DISABLE.
REQ-016 PAIR=1 step: AREG<=AREG±1 modulo 2^WIDTH; CARRY SHALL set on all-ones->0 (inc) or 0->all-ones (dec).
REQ-017 PAIR=0 step: only AREG[HALF-1:0] SHALL change, modulo 2^HALF; the high half SHALL be unchanged; CARRY SHALL set on a low-half wrap.
REQ-018 CARRY SHALL be sticky until the next command accept or reset; LD SHALL NOT clear CARRY.
REQ-019 A SHALL update to the post-edge AREG value at every edge where BUS_DISABLE=0, and SHALL hold at every edge where BUS_DISABLE=1.
REQ-020 A LD with BUS_DISABLE=1 SHALL update AREG but not A.
REQ-021 AREG_Q SHALL always show AREG.
REQ-022 Command inputs SHALL be ignored outside an accept cycle.

Reset
REQ-023 RES=1 SHALL immediately, without waiting for CLK, force AREG=0, A=0, REM=0, CARRY=0 and state=IDLE; outputs DONE=0 and CMD_READY=1 (when LD=0).
REQ-024 RES asserted mid-RUN SHALL discard the command, with no DONE pulse after release.
REQ-025 First accept after RES release SHALL be possible on the first rising edge.

Verification (WIDTH=16, CNTW=8)
REQ-026 LD 0x12FF; inc, PAIR=1, CNT=1 -> AREG=A=0x1300, CARRY=0, DONE high one cycle after the step edge.
REQ-027 LD 0x12FF; inc, PAIR=0, CNT=2 -> 0x1200 then 0x1201; CARRY=1; high byte stays 0x12.
REQ-028 LD 0x0000; dec, PAIR=1, CNT=1 -> 0xFFFF, CARRY=1; then CNT=0 command -> DONE next cycle, AREG 0xFFFF, CARRY=0.
REQ-029 LD 0x0100; inc, PAIR=1, CNT=3; BUS_DISABLE=1 for 2 edges after the first step -> A holds 0x0101 those cycles; final 0x0103; DONE delayed 2 cycles.
REQ-030 LD 0xABCD during RUN -> AREG=0xABCD, state IDLE, no DONE, CMD_READY=1 the next cycle.
REQ-031 RES pulsed between edges mid-RUN -> A=0, CARRY=0, CMD_READY=1 before the next edge; no DONE afterwards.

Source files
------------

// File: rtl/incdec_ex.sv
// rtl/incdec_ex.sv - address incrementer/decrementer with stepped commands, bus freeze and sticky carry
module incdec_ex #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 8
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             LD,
    input  logic [WIDTH-1:0] DIN,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_DEC,
    input  logic             CMD_PAIR,
    input  logic [CNTW-1:0]  CMD_CNT,
    input  logic             BUS_DISABLE,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] AREG_Q,
    output logic             CARRY,
    output logic             DONE
);

    localparam int HALF = WIDTH / 2;

    localparam logic [WIDTH-1:0] FULL_ONE  = WIDTH'(1);
    localparam logic [HALF-1:0]  HALF_ONE  = HALF'(1);
    localparam logic [CNTW-1:0]  CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0]  CNT_ZERO  = '0;
    localparam logic [WIDTH-1:0] FULL_ONES = '1;
    localparam logic [HALF-1:0]  HALF_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CNTW-1:0]  rem_q, rem_d;
    logic             carry_q, carry_d;
    logic             dec_q, dec_d;
    logic             pair_q, pair_d;

    logic [WIDTH-1:0] step_val;
    logic             step_wrap;
    logic [HALF-1:0]  low_cur;
    logic [HALF-1:0]  low_nxt;

    // One step of the latched command: full-width or low-half only, with wrap detect
    always_comb begin
        step_val  = areg_q;
        step_wrap = 1'b0;
        low_cur   = areg_q[HALF-1:0];
        low_nxt   = dec_q ? (low_cur - HALF_ONE) : (low_cur + HALF_ONE);
        if (pair_q) begin
            step_val  = dec_q ? (areg_q - FULL_ONE) : (areg_q + FULL_ONE);
            step_wrap = dec_q ? (areg_q == '0) : (areg_q == FULL_ONES);
        end else begin
            step_val  = {areg_q[WIDTH-1:HALF], low_nxt};
            step_wrap = dec_q ? (low_cur == '0) : (low_cur == HALF_ONES);
        end
    end

    // Next-state: LD has priority over everything (load in IDLE, abort elsewhere)
    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        dec_d   = dec_q;
        pair_d  = pair_q;
        if (LD) begin
            areg_d  = DIN;
            state_d = ST_IDLE;
            rem_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        dec_d   = CMD_DEC;
                        pair_d  = CMD_PAIR;
                        rem_d   = CMD_CNT;
                        carry_d = 1'b0;
                        state_d = (CMD_CNT != CNT_ZERO) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (!BUS_DISABLE) begin
                        areg_d  = step_val;
                        carry_d = carry_q | step_wrap;
                        rem_d   = rem_q - CNT_ONE;
                        if (rem_q == CNT_ONE) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // External address follows the register only while the bus is enabled
        a_d = BUS_DISABLE ? a_q : areg_d;
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= ST_IDLE;
            areg_q  <= '0;
            a_q     <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
            dec_q   <= 1'b0;
            pair_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            a_q     <= a_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
            dec_q   <= dec_d;
            pair_q  <= pair_d;
        end
    end

    assign CMD_READY = (state_q == ST_IDLE) & ~LD;
    assign DONE      = (state_q == ST_DONE);
    assign A         = a_q;
    assign AREG_Q    = areg_q;
    assign CARRY     = carry_q;

endmodule

// File: tb/tb_incdec_ex.sv
// tb/tb_incdec_ex.sv - directed self-checking bench for incdec_ex
module tb_incdec_ex;

    logic        clk;
    logic        res;
    logic        ld;
    logic [15:0] din;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dec;
    logic        cmd_pair;
    logic [7:0]  cmd_cnt;
    logic        bus_disable;
    logic [15:0] a;
    logic [15:0] areg;
    logic        carry;
    logic        done;

    int n_checks;
    int n_pass;

    incdec_ex #(.WIDTH(16), .CNTW(8)) dut (
        .CLK        (clk),
        .RES        (res),
        .LD         (ld),
        .DIN        (din),
        .CMD_VALID  (cmd_valid),
        .CMD_READY  (cmd_ready),
        .CMD_DEC    (cmd_dec),
        .CMD_PAIR   (cmd_pair),
        .CMD_CNT    (cmd_cnt),
        .BUS_DISABLE(bus_disable),
        .A          (a),
        .AREG_Q     (areg),
        .CARRY      (carry),
        .DONE       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        ld  = 1'b1;
        din = v;
        tick();
        ld  = 1'b0;
    endtask

    task automatic issue(input logic dec, input logic pair, input logic [7:0] cnt);
        cmd_valid = 1'b1;
        cmd_dec   = dec;
        cmd_pair  = pair;
        cmd_cnt   = cnt;
        tick();
        cmd_valid = 1'b0;
        cmd_dec   = 1'b0;
        cmd_pair  = 1'b0;
        cmd_cnt   = 8'd0;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        res         = 1'b1;
        ld          = 1'b0;
        din         = 16'h0;
        cmd_valid   = 1'b0;
        cmd_dec     = 1'b0;
        cmd_pair    = 1'b0;
        cmd_cnt     = 8'd0;
        bus_disable = 1'b0;

        // reset state, observed before any clock edge
        #2;
        check("rst_a", a, 16'h0);
        check("rst_areg", areg, 16'h0);
        check("rst_carry", carry, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        tick();
        res = 1'b0;

        // inc full width across byte boundary
        load(16'h12FF);
        check("ld_areg", areg, 16'h12FF);
        check("ld_a", a, 16'h12FF);
        cmd_valid = 1'b1;
        #1;
        check("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b0;
        issue(1'b0, 1'b1, 8'd1);
        check("run_ready", cmd_ready, 0);
        check("run_done0", done, 0);
        tick();
        check("inc_areg", areg, 16'h1300);
        check("inc_a", a, 16'h1300);
        check("inc_carry", carry, 0);
        check("inc_done", done, 1);
        tick();
        check("inc_done_end", done, 0);
        check("inc_ready_back", cmd_ready, 1);

        // inc low half only, wraps low byte
        load(16'h12FF);
        issue(1'b0, 1'b0, 8'd2);
        tick();
        check("half_s1", areg, 16'h1200);
        check("half_c1", carry, 1);
        check("half_d1", done, 0);
        tick();
        check("half_s2", areg, 16'h1201);
        check("half_c2", carry, 1);
        check("half_d2", done, 1);
        tick();

        // dec full width from zero, then zero-count command
        load(16'h0000);
        check("ld_keeps_carry", carry, 1);
        issue(1'b1, 1'b1, 8'd1);
        check("accept_clr_carry", carry, 0);
        tick();
        check("dec_areg", areg, 16'hFFFF);
        check("dec_carry", carry, 1);
        check("dec_done", done, 1);
        tick();
        issue(1'b0, 1'b1, 8'd0);
        check("cnt0_done", done, 1);
        check("cnt0_areg", areg, 16'hFFFF);
        check("cnt0_carry", carry, 0);
        tick();
        check("cnt0_done_end", done, 0);

        // bus freeze pauses stepping and holds A
        load(16'h0100);
        issue(1'b0, 1'b1, 8'd3);
        tick();
        check("bd_s1", a, 16'h0101);
        bus_disable = 1'b1;
        tick();
        check("bd_hold1_a", a, 16'h0101);
        check("bd_hold1_r", areg, 16'h0101);
        tick();
        check("bd_hold2_a", a, 16'h0101);
        check("bd_hold2_d", done, 0);
        bus_disable = 1'b0;
        tick();
        check("bd_s2", a, 16'h0102);
        check("bd_s2_d", done, 0);
        tick();
        check("bd_s3", a, 16'h0103);
        check("bd_done", done, 1);
        tick();
        check("bd_done_end", done, 0);

        // load aborts a running command
        load(16'h0000);
        issue(1'b0, 1'b1, 8'd5);
        tick();
        check("ab_s1", areg, 16'h0001);
        ld  = 1'b1;
        din = 16'hABCD;
        #1;
        check("ab_ready_ld", cmd_ready, 0);
        tick();
        ld = 1'b0;
        #1;
        check("ab_areg", areg, 16'hABCD);
        check("ab_a", a, 16'hABCD);
        check("ab_ready", cmd_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ab_no_done", done, 0);
        end
        check("ab_areg_hold", areg, 16'hABCD);

        // load while bus disabled changes AREG only
        bus_disable = 1'b1;
        load(16'h5555);
        bus_disable = 1'b0;
        check("ldbd_areg", areg, 16'h5555);
        check("ldbd_a", a, 16'hABCD);

        // asynchronous reset mid-run
        load(16'h0000);
        issue(1'b1, 1'b1, 8'd10);
        tick();
        check("rr_s1", areg, 16'hFFFF);
        check("rr_c1", carry, 1);
        #2;
        res = 1'b1;
        #1;
        check("rr_a", a, 16'h0);
        check("rr_areg", areg, 16'h0);
        check("rr_carry", carry, 0);
        check("rr_ready", cmd_ready, 1);
        check("rr_done", done, 0);
        #1;
        res = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rr_no_done", done, 0);
        end
        check("rr_areg_hold", areg, 16'h0);

        // accept on first edge after reset release
        #2;
        res = 1'b1;
        #1;
        res = 1'b0;
        issue(1'b0, 1'b1, 8'd1);
        check("post_rst_run", cmd_ready, 0);
        tick();
        check("post_rst_areg", areg, 16'h0001);
        check("post_rst_done", done, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
